// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo, rem;

  // Signed ops (op[0]==0) work on magnitudes; signs are restored in FIX.
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? ('0 - a) : a;
  assign b_mag = b_neg ? ('0 - b) : b;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcand_q};

`ifdef MULDIV_FAST_MUL_EN
  assign prod_mag = {{WIDTH{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
  assign prod_mag = acc_q;
`endif

  assign prod = (sa_q ^ sb_q) ? ('0 - prod_mag) : prod_mag;
  assign quo  = (sa_q ^ sb_q) ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem  = sa_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d    = op;
          sa_d    = a_neg;
          sb_d    = b_neg;
          bz_d    = (b == '0);
          mcand_d = op[1] ? b_mag : a_mag;
          acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          rem_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) state_d = StFix;
`endif
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (op_q[1]) begin
            // Restoring step: quotient bit shifts in at the bottom of acc.
            if (!div_trial[WIDTH]) begin
              rem_d = div_trial;
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = div_shift;
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            hi_d = rem;
            lo_d = bz_q ? '1 : quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32), with hand-computed results.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = W + 2;
`endif
  localparam int DivLat = W + 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues the op and waits (bounded) for done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] ra,
                        input logic [W-1:0] rb, input bit poke, input int exp_lat,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int n;
    bit got, busy_ok;
    n = 0; got = 0; busy_ok = 1;
    start = 1'b1; op = o; a = ra; b = rb;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (poke && n == 5) begin start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd5; end
      if (poke && n == 6) start = 1'b0;
      if (done) got = 1;
      else if (!busy) busy_ok = 0;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    bit saw_done;
    resetn = 1'b0; start = 0; flush = 0; hi_we = 0; lo_we = 0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    run_op("mult", 2'b00, 32'hFFFF_FFFD, 32'd5, 0, MulLat, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, MulLat, 32'hFFFF_FFFE, 32'h1);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, DivLat, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, DivLat, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, DivLat, 32'd0, 32'h8000_0000);
    run_op("divu_z", 2'b11, 32'd7, 32'd0, 0, DivLat, 32'd7, 32'hFFFF_FFFF);

    // MTHI, then a flushed divide must leave HI/LO alone.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", 64'(hi), 64'h1234);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    check("flush_nodone", 64'(saw_done), 64'd0);
    check("flush_hi", 64'(hi), 64'h1234);
    check("flush_lo", 64'(lo), 64'hFFFF_FFFF);
    run_op("divu_after", 2'b11, 32'd100, 32'd3, 0, DivLat, 32'd1, 32'd33);

    // Back-to-back: second start lands in the done cycle.
    run_op("b2b_1", 2'b01, 32'd6, 32'd7, 0, MulLat, 32'd0, 32'd42);
    run_op("b2b_2", 2'b11, 32'd50, 32'd7, 0, DivLat, 32'd1, 32'd7);

    // Start mid-operation is ignored.
    @(negedge clk);
    run_op("poke", 2'b11, 32'd1000, 32'd9, 1, DivLat, 32'd1, 32'd111);
    @(negedge clk);
    check("poke_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-CALC.
    start = 1'b1; op = 2'b11; a = 32'd77; b = 32'd4;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    check("pre_rst_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
